// File: rtl/dsp32_pkg.sv
// Shared DSP32 definitions.
// Holds the instruction-memory geometry, the fetch FSM state type and the
// packed {instr, pc} record that the fetch unit buffers and presents.
package dsp32_pkg;

    localparam int unsigned DSP32_IMEM_AW = 11;
    localparam int unsigned DSP32_INSTR_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DSP32_INSTR_W-1:0] instr;
        logic [DSP32_IMEM_AW-1:0] pc;
    } dsp32_fetch_t;

endpackage

// File: rtl/dsp32_sync_fifo.sv
// Synchronous FIFO with a registered first-word output.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (pointers and count to zero)
//   push, din    write one entry (ignored when full without a pop)
//   pop          remove the head entry (ignored when empty)
//   dout         registered head entry, stable until popped
//   count        number of stored entries, 0..DEPTH
module dsp32_sync_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            // Head register: bypass din when the entry becomes the new head,
            // otherwise advance to the entry behind the one being popped.
            if (do_push && ((count == '0) || ((count == CW'(1)) && do_pop))) begin
                dout <= din;
            end else if (do_pop && (count > CW'(1))) begin
                dout <= mem[rd_ptr + PW'(1)];
            end
        end
    end

endmodule

// File: rtl/dsp32_ifetch.sv
// DSP32 instruction fetch unit.
// Issues reads to port B of the instruction memory (read-only: write enable
// is tied low and the output-register enable tied high outside this block),
// buffers returned words with their PC in a prefetch FIFO and presents them
// to the decoder over valid/ready. Handles start, halt and branch redirect.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_pc       begin fetching at start_pc (IDLE only)
//   halt                  stop, flush, return to IDLE (wins over all)
//   busy                  high while fetching
//   imem_ce, imem_ad      memory read enable / address
//   imem_dout             memory read data, one cycle after imem_ce
//   instr_valid/data/pc   FIFO head towards the decoder
//   instr_ready           decoder accepts the head
//   redirect, redirect_pc branch taken: flush and refetch from redirect_pc
module dsp32_ifetch
    import dsp32_pkg::*;
#(
    parameter int unsigned ADDR_W     = DSP32_IMEM_AW,
    parameter int unsigned INSTR_W    = DSP32_INSTR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_pc,
    input  logic               halt,
    output logic               busy,
    output logic               imem_ce,
    output logic [ADDR_W-1:0]  imem_ad,
    input  logic [INSTR_W-1:0] imem_dout,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t               state;
    fetch_state_t               state_next;
    logic [ADDR_W-1:0]          fetch_pc;
    logic [ADDR_W-1:0]          tag_pc;
    logic                       inflight;
    logic                       kill;
    logic [CW-1:0]              fifo_count;
    logic [CW:0]                occupancy;
    logic                       room;
    logic                       flush;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic [INSTR_W+ADDR_W-1:0]  fifo_dout;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; halt overrides start
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start && !halt) state_next = FETCH;
            FETCH: if (halt)           state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Outputs: issue only when every outstanding response has a FIFO slot
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
        room      = occupancy < (CW+1)'(FIFO_DEPTH);
        busy      = (state == FETCH);
        imem_ce   = (state == FETCH) && !redirect && !halt && room;
    end

    assign imem_ad = fetch_pc;

    // Redirect is only honoured while fetching; halt flushes unconditionally.
    always_comb begin
        flush     = halt || (redirect && (state == FETCH));
        fifo_push = inflight && !redirect && !halt && !kill;
        fifo_pop  = instr_valid && instr_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= '0;
            tag_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            kill     <= redirect && (state == FETCH) && !halt;
            inflight <= imem_ce;
            if (imem_ce) begin
                tag_pc <= fetch_pc;
            end
            if ((state == IDLE) && start && !halt) begin
                fetch_pc <= start_pc;
            end else if ((state == FETCH) && redirect && !halt) begin
                fetch_pc <= redirect_pc;
            end else if (imem_ce) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    dsp32_sync_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (fifo_push),
        .din   ({imem_dout, tag_pc}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr_data  = fifo_dout[ADDR_W +: INSTR_W];
    assign instr_pc    = fifo_dout[ADDR_W-1:0];

endmodule

// File: tb/tb_dsp32_ifetch.sv
module tb_dsp32_ifetch;

    localparam int AW    = 11;
    localparam int IW    = 16;
    localparam int DEPTH = 4;
    localparam int NPC   = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_pc;
    logic          halt;
    logic          busy;
    logic          imem_ce;
    logic [AW-1:0] imem_ad;
    logic [IW-1:0] imem_dout;
    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;

    logic [IW-1:0] mem [NPC];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instruction memory port B: registered read, one-cycle latency
    always @(posedge clk) begin
        if (imem_ce) imem_dout <= mem[imem_ad];
    end

    dsp32_ifetch #(.ADDR_W(AW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .halt        (halt),
        .busy        (busy),
        .imem_ce     (imem_ce),
        .imem_ad     (imem_ad),
        .imem_dout   (imem_dout),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [AW-1:0] pc_add(input int base, input int k);
        return AW'((base + k) % NPC);
    endfunction

    task automatic do_halt();
        @(negedge clk); halt = 1'b1; instr_ready = 1'b0;
        @(negedge clk); halt = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_ce !== 1'b0) begin
            errors++;
            $display("FAIL halt_idle: busy=%b valid=%b ce=%b expected 0 0 0", busy, instr_valid, imem_ce);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_pc = '0; halt = 1'b0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #23;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (imem_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b expected 0", imem_ce); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_ad !== '0) begin errors++; $display("FAIL reset_ad: got %h expected 000", imem_ad); end
        checks++; if (instr_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0000", instr_data); end
        checks++; if (instr_pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 000", instr_pc); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_start_stream(input int spc, input int n);
        @(negedge clk); start = 1'b1; start_pc = AW'(spc); instr_ready = 1'b1;
        @(negedge clk); start = 1'b0; #1;
        checks++;
        if (imem_ce !== 1'b1 || imem_ad !== pc_add(spc, 0)) begin
            errors++; $display("FAIL start_c1: ce=%b ad=%h expected 1 %h", imem_ce, imem_ad, pc_add(spc, 0));
        end
        @(negedge clk); #1;
        checks++;
        if (imem_ce !== 1'b1 || imem_ad !== pc_add(spc, 1) || instr_valid !== 1'b0) begin
            errors++; $display("FAIL start_c2: ce=%b ad=%h valid=%b expected 1 %h 0", imem_ce, imem_ad, instr_valid, pc_add(spc, 1));
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== pc_add(spc, k) || instr_data !== mem[pc_add(spc, k)]) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h data=%h expected 1 %h %h", k, instr_valid, instr_pc, instr_data, pc_add(spc, k), mem[pc_add(spc, k)]);
            end
        end
        do_halt();
    endtask

    task automatic test_backpressure();
        int spc;
        int issues;
        int got;
        int budget;
        spc = int'($urandom_range(0, NPC - 1));
        @(negedge clk); start = 1'b1; start_pc = AW'(spc); instr_ready = 1'b0;
        issues = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); start = 1'b0; #1;
            if (imem_ce === 1'b1) issues++;
            if (c >= 3) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== pc_add(spc, 0) || instr_data !== mem[pc_add(spc, 0)]) begin
                    errors++;
                    $display("FAIL bp_hold_c%0d: valid=%b pc=%h data=%h expected 1 %h %h", c, instr_valid, instr_pc, instr_data, pc_add(spc, 0), mem[pc_add(spc, 0)]);
                end
            end
        end
        checks++; if (issues != DEPTH) begin errors++; $display("FAIL bp_issue_count: got %0d expected %0d", issues, DEPTH); end
        checks++; if (imem_ce !== 1'b0) begin errors++; $display("FAIL bp_ce_low: got %b expected 0", imem_ce); end
        got = 0;
        budget = 40;
        while (got < 8 && budget > 0) begin
            @(negedge clk); instr_ready = 1'b1; #1;
            if (instr_valid === 1'b1) begin
                checks++;
                if (instr_pc !== pc_add(spc, got) || instr_data !== mem[pc_add(spc, got)]) begin
                    errors++;
                    $display("FAIL bp_release_%0d: pc=%h data=%h expected %h %h", got, instr_pc, instr_data, pc_add(spc, got), mem[pc_add(spc, got)]);
                end
                got++;
            end
            budget--;
        end
        checks++; if (got != 8) begin errors++; $display("FAIL bp_release_timeout: got %0d entries expected 8", got); end
        do_halt();
    endtask

    task automatic test_redirect();
        @(negedge clk); start = 1'b1; start_pc = 11'h100; instr_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); start = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); instr_ready = 1'b1; #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== pc_add(32'h100, k)) begin
                errors++; $display("FAIL redir_pre_pop%0d: valid=%b pc=%h expected 1 %h", k, instr_valid, instr_pc, pc_add(32'h100, k));
            end
        end
        @(negedge clk); instr_ready = 1'b0; #1;
        checks++;
        if (imem_ce !== 1'b1 || imem_ad !== 11'h105) begin
            errors++; $display("FAIL redir_issue105: ce=%b ad=%h expected 1 105", imem_ce, imem_ad);
        end
        @(negedge clk); redirect = 1'b1; redirect_pc = 11'h200; #1;
        checks++;
        if (imem_ce !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 11'h102) begin
            errors++; $display("FAIL redir_cycle: ce=%b valid=%b pc=%h expected 0 1 102", imem_ce, instr_valid, instr_pc);
        end
        @(negedge clk); redirect = 1'b0; #1;
        checks++;
        if (imem_ce !== 1'b1 || imem_ad !== 11'h200 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL redir_r1: ce=%b ad=%h valid=%b expected 1 200 0", imem_ce, imem_ad, instr_valid);
        end
        @(negedge clk); #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r2: valid=%b expected 0", instr_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); instr_ready = 1'b1; #1;
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== pc_add(32'h200, k) || instr_data !== mem[pc_add(32'h200, k)]) begin
                errors++;
                $display("FAIL redir_r%0d: valid=%b pc=%h data=%h expected 1 %h %h", k + 3, instr_valid, instr_pc, instr_data, pc_add(32'h200, k), mem[pc_add(32'h200, k)]);
            end
        end
        do_halt();
    endtask

    task automatic test_halt_redirect();
        @(negedge clk); start = 1'b1; start_pc = AW'($urandom_range(0, NPC - 1)); instr_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); start = 1'b0;
        end
        @(negedge clk); halt = 1'b1; redirect = 1'b1; redirect_pc = AW'($urandom); start = 1'b1; #1;
        checks++; if (imem_ce !== 1'b0) begin errors++; $display("FAIL hr_cycle_ce: got %b expected 0", imem_ce); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); halt = 1'b0; start = 1'b0;
            // a redirect while IDLE must not wake the unit
            redirect = (c == 3); redirect_pc = 11'h055; #1;
            checks++;
            if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_ce !== 1'b0) begin
                errors++; $display("FAIL hr_idle_c%0d: busy=%b valid=%b ce=%b expected 0 0 0", c, busy, instr_valid, imem_ce);
            end
        end
        redirect = 1'b0;
        test_start_stream(32'h333, 3);
    endtask

    task automatic test_async_reset();
        @(negedge clk); start = 1'b1; start_pc = AW'($urandom_range(0, NPC - 1)); instr_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); start = 1'b0;
        end
        #2 rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || imem_ce !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL arst_ctrl: busy=%b ce=%b valid=%b expected 0 0 0", busy, imem_ce, instr_valid);
        end
        checks++;
        if (imem_ad !== '0 || instr_pc !== '0 || instr_data !== '0) begin
            errors++; $display("FAIL arst_data: ad=%h pc=%h data=%h expected 0 0 0", imem_ad, instr_pc, instr_data);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); #1;
            checks++;
            if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_ce !== 1'b0) begin
                errors++; $display("FAIL arst_after_c%0d: busy=%b valid=%b ce=%b expected 0 0 0", c, busy, instr_valid, imem_ce);
            end
        end
        test_start_stream(int'($urandom_range(0, NPC - 1)), 4);
    endtask

    // Reference: instructions are delivered in strict PC order from the last
    // start/redirect target; issues walk forward from the same target; the
    // number of issued-but-undelivered words never exceeds the FIFO depth.
    task automatic test_random();
        int exp_pc;
        int iss_pc;
        int outst;
        int delivered;
        bit hs;
        bit prev_hold;
        logic [AW-1:0] prev_pc;
        logic [IW-1:0] prev_data;
        exp_pc = int'($urandom_range(0, NPC - 1));
        iss_pc = exp_pc;
        outst = 0;
        delivered = 0;
        prev_hold = 1'b0;
        prev_pc = '0;
        prev_data = '0;
        @(negedge clk); start = 1'b1; start_pc = AW'(exp_pc); instr_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = AW'($urandom);
            #1;
            if (imem_ce === 1'b1) begin
                checks++;
                if (imem_ad !== AW'(iss_pc)) begin
                    errors++; $display("FAIL rnd_issue_c%0d: ad=%h expected %h", c, imem_ad, AW'(iss_pc));
                end
            end
            if (redirect) begin
                checks++;
                if (imem_ce !== 1'b0) begin errors++; $display("FAIL rnd_redir_ce_c%0d: ce=%b expected 0", c, imem_ce); end
            end
            if (prev_hold) begin
                checks++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_data !== prev_data) begin
                    errors++;
                    $display("FAIL rnd_hold_c%0d: valid=%b pc=%h data=%h expected 1 %h %h", c, instr_valid, instr_pc, instr_data, prev_pc, prev_data);
                end
            end
            hs = (instr_valid === 1'b1) && instr_ready;
            if (hs) begin
                checks++;
                if (instr_pc !== AW'(exp_pc) || instr_data !== mem[exp_pc]) begin
                    errors++;
                    $display("FAIL rnd_deliver_c%0d: pc=%h data=%h expected %h %h", c, instr_pc, instr_data, AW'(exp_pc), mem[exp_pc]);
                end
                delivered++;
            end
            if (redirect) begin
                exp_pc = int'(redirect_pc);
                iss_pc = exp_pc;
                outst = 0;
                prev_hold = 1'b0;
            end else begin
                if (hs) begin
                    exp_pc = (exp_pc + 1) % NPC;
                    outst--;
                end
                if (imem_ce === 1'b1) begin
                    iss_pc = (iss_pc + 1) % NPC;
                    outst++;
                end
                checks++;
                if (outst > DEPTH) begin errors++; $display("FAIL rnd_overfill_c%0d: outstanding=%0d limit %0d", c, outst, DEPTH); end
                prev_hold = (instr_valid === 1'b1) && !instr_ready;
                prev_pc = instr_pc;
                prev_data = instr_data;
            end
        end
        redirect = 1'b0;
        checks++;
        if (delivered < 100) begin errors++; $display("FAIL rnd_progress: delivered=%0d expected at least 100", delivered); end
        do_halt();
    endtask

    initial begin
        for (int i = 0; i < NPC; i++) mem[i] = IW'($urandom);
        test_reset();
        test_start_stream(32'h010, 6);
        test_start_stream(32'h7FE, 4);
        test_backpressure();
        test_redirect();
        test_halt_redirect();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/dsp32_ifetch.md
# dsp32_ifetch

Instruction fetch unit for the DSP32 coprocessor. It generates read addresses for port B of the 2K×16 DSP32 instruction memory and captures the returned words in a small prefetch FIFO. It presents instructions, tagged with their PC, to the DSP32 decoder over a valid/ready handshake. It also handles start, halt and branch redirect from the sequencer.

## Interface
- `ADDR_W`, default 11: instruction address width, 2048 words.
- `INSTR_W`, default 16: instruction width.
- `FIFO_DEPTH`, default 4: prefetch FIFO entries, a power of two and at least 2.

Ports:
- `clk`  in  1  the single clock. The instruction-memory port is clocked from it.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begin fetching at `start_pc`.
- `start_pc`  in  ADDR_W  start address.
- `halt`  in  1  one-cycle pulse; stop, flush, return to IDLE.
- `busy`  out  1  high while not IDLE.
- `imem_ce`  out  1  read enable to the instruction-memory port.
- `imem_ad`  out  ADDR_W  read address.
- `imem_dout`  in  INSTR_W  read data, valid the cycle after `imem_ce`.
- `instr_valid`  out  1  FIFO head valid.
- `instr_data`  out  INSTR_W  FIFO head instruction.
- `instr_pc`  out  ADDR_W  FIFO head address.
- `instr_ready`  in  1  decoder accepts the head.
- `redirect`  in  1  branch taken; discard prefetched state.
- `redirect_pc`  in  ADDR_W  branch target.

## Operation
- Memory port usage:
  - The port is read-only from this block; write enable is tied low at the top level.
  - Output-register enable is tied high.
  - Read latency is exactly 1 cycle.
- State machine:
  - States are IDLE and FETCH.
  - IDLE -> FETCH on `start`; `fetch_pc` is loaded with `start_pc`.
  - FETCH -> IDLE on `halt`.
  - `start` while in FETCH is ignored.
  - `redirect` in IDLE is ignored.
- Issue rule, in FETCH:
  - `imem_ce` = !`redirect` & !`halt` & (`fifo_count` + `inflight` < `FIFO_DEPTH`).
  - `imem_ce` and `imem_ad` are combinational from registered state; `imem_ad` = `fetch_pc`.
  - On issue, `fetch_pc` increments modulo 2^ADDR_W, so 0x7FF wraps to 0x000.
  - `inflight` is 1 for the cycle after an issue. Each request carries its PC in a 1-deep tag register.
- Capture:
  - In the cycle `inflight`=1, {`imem_dout`, tag PC} is written into the FIFO unless a kill condition holds.
  - Kill conditions: `redirect`, `halt`, or a kill flag set by a redirect in the previous cycle.
- Consume: the FIFO pops when `instr_valid` & `instr_ready`.
- Redirect:
  - The FIFO is cleared at the clock edge and `fetch_pc` loads `redirect_pc`.
  - Any response from a request issued before or during the redirect cycle is discarded.
  - A handshake completing in the redirect cycle counts as delivered.
- Halt:
  - Same flush as redirect; state goes to IDLE.
  - Halt takes precedence over a simultaneous redirect or start.
- Reset: all registers clear; state is IDLE; `fetch_pc` is 0.

## Timing
- Reset values: `busy`, `imem_ce`, `instr_valid` = 0; `imem_ad`, `instr_data`, `instr_pc` = 0.
- `start` sampled at edge 0:
  - `imem_ce` high in cycle 1 with `imem_ad`=`start_pc`.
  - Data returns in cycle 2 and is written to the FIFO at the end of cycle 2.
  - `instr_valid` rises in cycle 3. Start-to-first-instruction latency is 3 cycles.
- Redirect asserted in cycle r:
  - `imem_ce`=0 in cycle r.
  - `imem_ce` high in cycle r+1 with `redirect_pc`.
  - `instr_valid` is low in cycles r+1 and r+2 and rises in cycle r+3.
- Throughput: 1 instruction per cycle sustained while `instr_ready` stays high.
- Back-pressure: with `instr_ready` low, the FIFO fills to `FIFO_DEPTH` and `imem_ce` then stays low. No entry is ever overwritten.
- `instr_data`/`instr_pc` hold stable while `instr_valid` & !`instr_ready`.

## Structure
- Shared package `dsp32_pkg` holds:
  - `DSP32_IMEM_AW` = 11 and `DSP32_INSTR_W` = 16;
  - the fetch state type {IDLE, FETCH};
  - a packed struct `dsp32_fetch_t` {instr, pc}.
- Sub-module `dsp32_sync_fifo`, parameterised by width and depth:
  - synchronous clear, push, pop and count;
  - reads from a register array; first-word output is registered.
- Top-level `dsp32_ifetch` contains the FSM, PC, issue and credit logic, and the kill logic. Target size is about 200 lines.

## Test plan
- Reset, then `start` with `start_pc`=0x010 and `instr_ready`=1 → `imem_ad` 0x010, 0x011, …; first `instr_valid` in cycle 3 with pc=0x010 and data = memory word 0x010; then 1 instruction per cycle.
- `start_pc`=0x7FE → delivered PCs are 0x7FE, 0x7FF, 0x000, 0x001 (wrap).
- `instr_ready`=0 for 10 cycles → exactly 4 entries buffered, `imem_ce` low; release `instr_ready` → PCs continue in order with no gap or duplicate.
- `redirect` to 0x200 while 0x105 is in flight and the FIFO holds 0x102–0x104 → none of 0x103–0x105 is delivered; next `instr_valid` is 3 cycles later with pc=0x200.
- `halt` and `redirect` in the same cycle → IDLE, `busy`=0, FIFO empty, no further `imem_ce`; a subsequent `start` restarts cleanly.
- `rst_n` asserted mid-stream (asynchronously) → all outputs 0 immediately; no `instr_valid` until a new `start`.
